// File: rtl/bus_pkg.sv
// Shared bus beat definitions for bus_t producers,
// consumers and the elastic buffer between them.
package bus_pkg;

  localparam int BUS_DATA_W = 8;

  typedef struct packed {
    logic [BUS_DATA_W-1:0] data;
    logic                  valid;
    logic                  ready;
  } bus_t;

  localparam bus_t BUS_IDLE = '0;

  // Build a beat from its fields.
  function automatic bus_t bus_beat(
    input logic [BUS_DATA_W-1:0] d,
    input logic                  v,
    input logic                  r
  );
    bus_t b;
    b.data  = d;
    b.valid = v;
    b.ready = r;
    return b;
  endfunction

endpackage

// File: rtl/bus_fifo_mem.sv
// Beat storage: DEPTH x BUS_DATA_W register array,
// one write port, one asynchronous read port, no reset.
module bus_fifo_mem
  import bus_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [BUS_DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [BUS_DATA_W-1:0] rdata_o
);

  logic [BUS_DATA_W-1:0] mem_q [DEPTH];

  // Write the accepted beat into its slot.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bus_fifo.sv
// Elastic first-word-fall-through buffer for bus_t
// beats; drops and counts beats offered while full.
module bus_fifo
  import bus_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  bus_t                     bus_in,
  output logic                     in_ready,
  output bus_t                     bus_out,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]         wr_q, wr_d;
  logic [AW-1:0]         rd_q, rd_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DROP_W-1:0]     drop_q, drop_d;
  logic                  offer;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic [BUS_DATA_W-1:0] rd_data;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

  // in_ready comes from registered state only, never out_ready.
  assign in_ready = !full;

  assign offer = bus_in.valid && bus_in.ready;
  assign push  = offer && !full;
  assign drop  = offer && full;
  assign pop   = !empty && out_ready;

  bus_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (push && !rst),
    .waddr_i (wr_q),
    .wdata_i (bus_in.data),
    .raddr_i (rd_q),
    .rdata_o (rd_data)
  );

  // Next-state for pointers, occupancy and drop counter.
  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    drop_d = drop_q;
    if (push) begin
      wr_d = wr_q + AW'(1);
    end
    if (pop) begin
      rd_d = rd_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (drop && (drop_q != '1)) begin
      drop_d = drop_q + DROP_W'(1);
    end
  end

  // Register state; reset discards buffered beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      drop_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
    end
  end

  // Head beat; zero when empty so stale memory never leaks out.
  always_comb begin
    bus_out = BUS_IDLE;
    if (!empty) begin
      bus_out = bus_beat(rd_data, 1'b1, out_ready);
    end
  end

  assign count    = cnt_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_bus_fifo.sv
// Self-checking bench for bus_fifo: queue model plus
// directed scenarios with literal expectations.
module tb_bus_fifo;
  import bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  bus_t        bus_in = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, in_ready_s;
  bus_t        bus_out, bus_out_s;
  logic [2:0]  count, count_s;
  logic        full, full_s, empty, empty_s;
  logic [15:0] drop_cnt;
  logic [1:0]  drop_cnt_s;

  int tests = 0;
  int fails = 0;
  bit armed = 1'b0;

  byte unsigned mq[$];
  byte unsigned seen[$];
  int mdrop = 0;
  int mdrop_s = 0;

  always #5 clk = ~clk;

  bus_fifo #(.DEPTH(4), .DROP_W(16)) dut (
    .clk(clk), .rst(rst), .bus_in(bus_in),
    .in_ready(in_ready), .bus_out(bus_out),
    .out_ready(out_ready), .count(count),
    .full(full), .empty(empty),
    .drop_cnt(drop_cnt)
  );

  bus_fifo #(.DEPTH(4), .DROP_W(2)) dut_s (
    .clk(clk), .rst(rst), .bus_in(bus_in),
    .in_ready(in_ready_s), .bus_out(bus_out_s),
    .out_ready(out_ready), .count(count_s),
    .full(full_s), .empty(empty_s),
    .drop_cnt(drop_cnt_s)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic drive(input logic v,
                       input logic [7:0] d,
                       input logic ordy);
    bus_in.data  = d;
    bus_in.valid = v;
    bus_in.ready = v;
    out_ready    = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Model: a plain queue of up to four bytes.
  always @(posedge clk) begin
    bit mfull, mempty, moffer;
    byte unsigned tmp;
    if (rst) begin
      mq.delete();
      mdrop = 0;
      mdrop_s = 0;
    end else begin
      mfull  = (mq.size() == 4);
      mempty = (mq.size() == 0);
      moffer = bus_in.valid && bus_in.ready;
      if (!mempty && out_ready) tmp = mq.pop_front();
      if (moffer && !mfull) mq.push_back(bus_in.data);
      if (moffer && mfull) begin
        if (mdrop < 65535) mdrop++;
        if (mdrop_s < 3) mdrop_s++;
      end
    end
  end

  // Sink: capture beats on valid && ready.
  always @(posedge clk) begin
    if (!rst && bus_out.valid && bus_out.ready)
      seen.push_back(bus_out.data);
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    bit v;
    if (armed) begin
      v = (mq.size() != 0);
      chk("valid", bus_out.valid, v);
      chk("data", bus_out.data,
          v ? mq[0] : 8'h00);
      chk("oready", bus_out.ready, out_ready && v);
      chk("count", count, mq.size());
      chk("full", full, mq.size() == 4);
      chk("empty", empty, !v);
      chk("in_ready", in_ready, mq.size() != 4);
      chk("drop_cnt", drop_cnt, mdrop);
      chk("drop_cnt_s", drop_cnt_s, mdrop_s);
    end
  end

  initial begin
    int idx;
    int c;
    drive(0, 8'h00, 0);
    rst = 1'b1;
    tick();
    armed = 1'b1;
    tick();
    rst = 1'b0;

    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_inrdy", in_ready, 1);
    chk("rst_busout", bus_out, 0);
    chk("rst_drop", drop_cnt, 0);

    drive(1, 8'h5A, 0);
    tick();
    drive(0, 8'h00, 0);
    chk("one_valid", bus_out.valid, 1);
    chk("one_data", bus_out.data, 8'h5A);
    chk("one_count", count, 1);
    drive(0, 8'h00, 1);
    tick();
    chk("one_empty", empty, 1);
    chk("one_busout", bus_out, 0);
    drive(0, 8'h00, 0);

    for (int i = 1; i <= 4; i++) begin
      drive(1, 8'(i), 0);
      tick();
    end
    drive(0, 8'h00, 0);
    chk("fill_full", full, 1);
    chk("fill_inrdy", in_ready, 0);
    chk("fill_count", count, 4);
    seen.delete();
    drive(0, 8'h00, 1);
    repeat (6) tick();
    drive(0, 8'h00, 0);
    chk("drain_n", seen.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < seen.size())
        chk("drain_ord", seen[i], i + 1);

    for (int i = 1; i <= 4; i++) begin
      drive(1, 8'(i), 0);
      tick();
    end
    drive(1, 8'hAA, 0); tick();
    drive(1, 8'hBB, 0); tick();
    drive(1, 8'hCC, 0); tick();
    drive(0, 8'h00, 0);
    chk("ovf_drop", drop_cnt, 3);
    chk("ovf_drop_s", drop_cnt_s, 3);
    chk("ovf_count", count, 4);
    chk("ovf_head", bus_out.data, 8'h01);
    drive(1, 8'hDD, 0); tick();
    chk("sat_drop", drop_cnt, 4);
    chk("sat_drop_s", drop_cnt_s, 3);

    seen.delete();
    drive(1, 8'hEE, 1); tick();
    chk("fpp_count", count, 3);
    chk("fpp_drop", drop_cnt, 5);
    chk("fpp_head", bus_out.data, 8'h02);
    drive(0, 8'h00, 1); tick();
    chk("pp_pre", count, 2);
    drive(1, 8'h77, 1); tick();
    chk("pp_count", count, 2);
    chk("pp_head", bus_out.data, 8'h04);
    drive(0, 8'h00, 1);
    repeat (3) tick();
    drive(0, 8'h00, 0);
    chk("pp_n", seen.size(), 5);
    if (seen.size() == 5) begin
      chk("pp_s0", seen[0], 8'h01);
      chk("pp_s3", seen[3], 8'h04);
      chk("pp_s4", seen[4], 8'h77);
    end

    seen.delete();
    idx = 0;
    c = 0;
    while (!(idx == 10 && empty) && c < 60) begin
      if (idx < 10 && in_ready) begin
        drive(1, 8'(8'h10 + idx), c[0]);
        idx++;
      end else begin
        drive(0, 8'h00, c[0]);
      end
      tick();
      c++;
    end
    drive(0, 8'h00, 0);
    chk("wrap_timeout", c < 60, 1);
    chk("wrap_n", seen.size(), 10);
    for (int i = 0; i < 10; i++)
      if (i < seen.size())
        chk("wrap_ord", seen[i], 8'h10 + i);

    drive(1, 8'h21, 0); tick();
    drive(1, 8'h22, 0); tick();
    drive(1, 8'h23, 0); tick();
    chk("mid_count", count, 3);
    drive(1, 8'h99, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 8'h00, 0);
    chk("mrst_count", count, 0);
    chk("mrst_valid", bus_out.valid, 0);
    chk("mrst_drop", drop_cnt, 0);
    drive(1, 8'h3C, 0); tick();
    drive(0, 8'h00, 0);
    chk("post_data", bus_out.data, 8'h3C);
    chk("post_count", count, 1);
    tick();

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
